// File: rtl/rotate_stage.sv
// rtl/rotate_stage.sv - serial 1600-bit rho lane-rotation stage
//
// Purpose: accepts a 1600-bit state one bit per cycle in slice-major order,
// stores it as 25 lanes x 64 bits, then streams the state back out in the
// same order with every lane rotated by its fixed rho offset.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset
//   start    - begin a new pass (honoured only when idle)
//   in_valid - qualifies din while loading
//   din      - serial input bit, slice z outer (0..63), lane L inner (0..24)
//   ready    - high while the stage is loading
//   en       - qualifies pout, high for 1600 consecutive cycles per pass
//   pout     - serial rotated output bit, same ordering as din
//   co_c25   - marks the output cycle carrying lane 24 of a slice
//   co_c64   - marks the output cycles of slice 63
//   done     - one-cycle pulse after the final output bit
module rotate_stage (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  input  logic din,
  output logic ready,
  output logic en,
  output logic pout,
  output logic co_c25,
  output logic co_c64,
  output logic done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EMIT,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] c25_q, c25_d;
  logic [5:0] c64_q, c64_d;

  logic ready_q, ready_d;
  logic en_q, en_d;
  logic pout_q, pout_d;
  logic co25_q, co25_d;
  logic co64_q, co64_d;
  logic done_q, done_d;

  // Lane storage, indexed [lane][slice]; never reset because every bit is
  // rewritten during LOAD before EMIT reads it.
  logic [63:0] a_q [25];

  logic        wr_en;
  logic        last_pos;
  logic [63:0] rd_lane;
  logic [5:0]  rd_slice;

  // Per-lane rho rotation amounts.
  function automatic logic [5:0] rho_off(input logic [4:0] lane);
    case (lane)
      5'd0:    rho_off = 6'd0;
      5'd1:    rho_off = 6'd1;
      5'd2:    rho_off = 6'd62;
      5'd3:    rho_off = 6'd28;
      5'd4:    rho_off = 6'd27;
      5'd5:    rho_off = 6'd36;
      5'd6:    rho_off = 6'd44;
      5'd7:    rho_off = 6'd6;
      5'd8:    rho_off = 6'd55;
      5'd9:    rho_off = 6'd20;
      5'd10:   rho_off = 6'd3;
      5'd11:   rho_off = 6'd10;
      5'd12:   rho_off = 6'd43;
      5'd13:   rho_off = 6'd25;
      5'd14:   rho_off = 6'd39;
      5'd15:   rho_off = 6'd41;
      5'd16:   rho_off = 6'd45;
      5'd17:   rho_off = 6'd15;
      5'd18:   rho_off = 6'd21;
      5'd19:   rho_off = 6'd8;
      5'd20:   rho_off = 6'd18;
      5'd21:   rho_off = 6'd2;
      5'd22:   rho_off = 6'd61;
      5'd23:   rho_off = 6'd56;
      5'd24:   rho_off = 6'd14;
      default: rho_off = 6'd0;
    endcase
  endfunction

  assign last_pos = (c25_q == 5'd24) && (c64_q == 6'd63);

  always_comb begin
    state_d = state_q;
    c25_d   = c25_q;
    c64_d   = c64_q;
    wr_en   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          c25_d   = 5'd0;
          c64_d   = 6'd0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (last_pos) begin
            state_d = S_EMIT;
            c25_d   = 5'd0;
            c64_d   = 6'd0;
          end else if (c25_q == 5'd24) begin
            c25_d = 5'd0;
            c64_d = c64_q + 6'd1;
          end else begin
            c25_d = c25_q + 5'd1;
          end
        end
      end
      S_EMIT: begin
        if (last_pos) begin
          state_d = S_DONE;
          c25_d   = 5'd0;
          c64_d   = 6'd0;
        end else if (c25_q == 5'd24) begin
          c25_d = 5'd0;
          c64_d = c64_q + 6'd1;
        end else begin
          c25_d = c25_q + 5'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state counters, so the register
  // holds the bit for the position the counters point at during EMIT.
  // The wrap of the 6-bit subtraction gives the mod-64 rotation for free.
  always_comb begin
    rd_lane  = a_q[c25_d];
    rd_slice = c64_d - rho_off(c25_d);
    ready_d  = (state_d == S_LOAD);
    en_d     = (state_d == S_EMIT);
    pout_d   = en_d & rd_lane[rd_slice];
    co25_d   = en_d & (c25_d == 5'd24);
    co64_d   = en_d & (c64_d == 6'd63);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      c25_q   <= 5'd0;
      c64_q   <= 6'd0;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      pout_q  <= 1'b0;
      co25_q  <= 1'b0;
      co64_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c25_q   <= c25_d;
      c64_q   <= c64_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      pout_q  <= pout_d;
      co25_q  <= co25_d;
      co64_q  <= co64_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      a_q[c25_q][c64_q] <= din;
    end
  end

  assign ready  = ready_q;
  assign en     = en_q;
  assign pout   = pout_q;
  assign co_c25 = co25_q;
  assign co_c64 = co64_q;
  assign done   = done_q;

endmodule

// File: tb/tb_rotate_stage.sv
// tb/tb_rotate_stage.sv - self-checking bench for rotate_stage
module tb_rotate_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic din = 1'b0;
  logic ready, en, pout, co_c25, co_c64, done;

  int total = 0;
  int bad = 0;

  int rho_tb [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25,
                      39, 41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  // Model state: bit of lane L, slice z lives at st[L*64 + z].
  bit         st [1600];
  // Per-cycle vector {ready, en, pout, co_c25, co_c64, done}.
  logic [5:0] obs [1602];
  logic [5:0] exp_tr [1602];
  int         ready_miss;

  rotate_stage dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .din      (din),
    .ready    (ready),
    .en       (en),
    .pout     (pout),
    .co_c25   (co_c25),
    .co_c64   (co_c64),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic clear_state();
    for (int i = 0; i < 1600; i++) st[i] = 1'b0;
  endtask

  task automatic random_state();
    for (int i = 0; i < 1600; i++) st[i] = 1'($urandom_range(0, 1));
  endtask

  // Rho model: output index i = z*25 + L carries A[L][(z - r[L]) mod 64].
  task automatic build_expected();
    for (int i = 0; i < 1602; i++) begin
      if (i < 1600) begin
        int lane;
        int slice;
        bit b;
        lane  = i % 25;
        slice = i / 25;
        b = st[lane * 64 + ((slice - rho_tb[lane] + 64) % 64)];
        exp_tr[i] = {1'b0, 1'b1, b, (lane == 24), (slice == 63), 1'b0};
      end else if (i == 1600) begin
        exp_tr[i] = 6'b000001;
      end else begin
        exp_tr[i] = 6'b000000;
      end
    end
  endtask

  // Starts a pass and feeds the model state; stall=1 uses a 1,0,0 in_valid
  // pattern. Returns at the negedge of the first expected output cycle.
  task automatic do_load(input bit stall);
    int idx;
    int cyc;
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    din      = 1'($urandom_range(0, 1));
    @(negedge clk);
    idx = 0;
    cyc = 0;
    ready_miss = 0;
    while (idx < 1600) begin
      if (ready !== 1'b1) ready_miss++;
      start = 1'($urandom_range(0, 1));
      if (stall && (cyc % 3 != 0)) begin
        in_valid = 1'b0;
        din      = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b1;
        din      = st[(idx % 25) * 64 + (idx / 25)];
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  // Records 1602 cycles; start/in_valid are random noise that must be
  // ignored. Ends on the first idle cycle without advancing past it.
  task automatic capture();
    for (int i = 0; i < 1602; i++) begin
      obs[i] = {ready, en, pout, co_c25, co_c64, done};
      if (i < 1601) begin
        start    = 1'($urandom_range(0, 1));
        in_valid = 1'($urandom_range(0, 1));
        din      = 1'($urandom_range(0, 1));
        @(negedge clk);
      end else begin
        start    = 1'b0;
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({ready, en, pout, co_c25, co_c64, done} !== 6'b0) begin
      bad++;
      $display("FAIL reset_hold got=%b exp=000000", {ready, en, pout, co_c25, co_c64, done});
    end
    start = 1'b0;
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({ready, en, pout, co_c25, co_c64, done} !== 6'b0) begin
      bad++;
      $display("FAIL reset_idle got=%b exp=000000", {ready, en, pout, co_c25, co_c64, done});
    end
  endtask

  task automatic test_identity();
    int ones;
    clear_state();
    st[0 * 64 + 5] = 1'b1;
    build_expected();
    do_load(1'b0);
    capture();
    for (int i = 0; i < 1602; i++) begin
      total++;
      if (obs[i] !== exp_tr[i]) begin
        bad++;
        $display("FAIL identity idx=%0d got=%b exp=%b", i, obs[i], exp_tr[i]);
      end
    end
    ones = 0;
    for (int i = 0; i < 1600; i++) ones += int'(obs[i][3]);
    total++;
    if (ones !== 1 || obs[125][3] !== 1'b1) begin
      bad++;
      $display("FAIL identity_single ones=%0d bit125=%b exp ones=1 bit125=1", ones, obs[125][3]);
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 2; k++) begin
      clear_state();
      if (k == 0) st[2 * 64 + 0] = 1'b1;
      else        st[1 * 64 + 63] = 1'b1;
      build_expected();
      do_load(1'b0);
      capture();
      for (int i = 0; i < 1602; i++) begin
        total++;
        if (obs[i] !== exp_tr[i]) begin
          bad++;
          $display("FAIL wrap%0d idx=%0d got=%b exp=%b", k, i, obs[i], exp_tr[i]);
        end
      end
    end
  endtask

  task automatic test_stalls();
    random_state();
    build_expected();
    for (int k = 0; k < 2; k++) begin
      do_load(k == 0);
      total++;
      if (ready_miss !== 0) begin
        bad++;
        $display("FAIL stall_ready mode=%0d low_cycles=%0d exp=0", k, ready_miss);
      end
      capture();
      for (int i = 0; i < 1602; i++) begin
        total++;
        if (obs[i] !== exp_tr[i]) begin
          bad++;
          $display("FAIL stall mode=%0d idx=%0d got=%b exp=%b", k, i, obs[i], exp_tr[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 3; p++) begin
      random_state();
      build_expected();
      do_load(1'b0);
      capture();
      for (int i = 0; i < 1602; i++) begin
        total++;
        if (obs[i] !== exp_tr[i]) begin
          bad++;
          $display("FAIL b2b pass=%0d idx=%0d got=%b exp=%b", p, i, obs[i], exp_tr[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_emit();
    int noise;
    random_state();
    build_expected();
    do_load(1'b0);
    for (int i = 0; i < 800; i++) begin
      total++;
      if ({ready, en, pout, co_c25, co_c64, done} !== exp_tr[i]) begin
        bad++;
        $display("FAIL abort_prefix idx=%0d got=%b exp=%b", i,
                 {ready, en, pout, co_c25, co_c64, done}, exp_tr[i]);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({ready, en, pout, co_c25, co_c64, done} !== 6'b0) begin
      bad++;
      $display("FAIL abort_async got=%b exp=000000", {ready, en, pout, co_c25, co_c64, done});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    noise = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready !== 1'b0 || en !== 1'b0 || done !== 1'b0) noise++;
    end
    total++;
    if (noise !== 0) begin
      bad++;
      $display("FAIL abort_quiet active_cycles=%0d exp=0", noise);
    end
    random_state();
    build_expected();
    do_load(1'b0);
    capture();
    for (int i = 0; i < 1602; i++) begin
      total++;
      if (obs[i] !== exp_tr[i]) begin
        bad++;
        $display("FAIL abort_rerun idx=%0d got=%b exp=%b", i, obs[i], exp_tr[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_wrap();
    test_stalls();
    test_back_to_back();
    test_reset_mid_emit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
